qspi_flash_read_ctrl: RTL

Read-only QSPI flash sequencer that turns 32-bit word read requests from the tile's memory side into Quad Output Fast Read (0x6B) transactions on the board's S25FL128S-class flash pins. It owns chip select, SCK generation, the per-bit output-enable pattern and nibble assembly. It sits between the tile's instruction/data fetch port and the top-level `io_qspi_*` pads, and replaces the free-running prescaled clock used in simulation.

---
 rtl/qspi_flash_read_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/qspi_flash_read_ctrl.sv
// qspi_flash_read_ctrl: read-only Quad Output Fast Read (0x6B) sequencer.
// Turns 32-bit word read requests into complete QSPI flash transactions.
// It drives chip select, the mode-0 SCK, the per-bit output enables and
// assembles the returned nibbles into a little-endian word.
// Optional feature: define QSPI_FLASH_BURST_EN to keep CS low after a
// response. A following sequential word read then continues with the data
// phase only.
module qspi_flash_read_ctrl #(
  parameter int PRESCALER      = 2,  // clocks per SCK half-period, 1..15
  parameter int DUMMY_CYCLES   = 6,  // SCK cycles between address and data
  parameter int CS_HIGH_CYCLES = 4   // minimum CS-high clocks between frames
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        qspi_cs,
  output logic        qspi_sck,
  output logic [3:0]  qspi_dq_o,
  output logic [3:0]  qspi_dq_oe,
  input  logic [3:0]  qspi_dq_i
);

`ifdef QSPI_FLASH_BURST_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_RESP, S_DESEL, S_HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_RESP, S_DESEL
  } state_t;
`endif

  localparam logic [7:0] CMD_QOFR   = 8'h6B;
  localparam logic [3:0] DIV_MAX    = 4'(PRESCALER - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] DESEL_LAST = 8'(CS_HIGH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_div;         // clocks spent in the current SCK half-period
  logic        r_sck;
  logic [7:0]  r_cnt;         // SCK cycles in a phase, or CS-high clocks
  logic [31:0] r_shift;       // command + address, MSB goes out on dq[0]
  logic [31:0] r_data;
  logic        r_resp_valid;
  logic        r_cs;
  logic [3:0]  r_oe;

  logic [23:0] w_addr_aligned;
  logic        w_active, w_tick, w_rise, w_fall, w_phase_last, w_end;
  logic        w_desel_done;

  assign w_addr_aligned = req_addr & 24'hFF_FFFC;
  assign w_active       = (r_state == S_CMD) || (r_state == S_ADDR) ||
                          (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_tick         = w_active && (r_div == DIV_MAX);
  assign w_rise         = w_tick && !r_sck;
  assign w_fall         = w_tick && r_sck;
  assign w_end          = w_fall && w_phase_last;
  assign w_desel_done   = (r_cnt == DESEL_LAST);

`ifdef QSPI_FLASH_BURST_EN
  logic [23:0] r_addr;        // address of the word last requested
  logic        r_pending;     // non-sequential request accepted in HOLD
  logic        w_seq;
  // 25-bit compare so the 0xFFFFFC -> 0x000000 wrap is never sequential.
  assign w_seq = (({1'b0, r_addr} + 25'd4) == {1'b0, w_addr_aligned});
`endif

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_data;
  assign qspi_cs    = r_cs;
  assign qspi_sck   = r_sck;
  assign qspi_dq_o  = {3'b000, r_shift[31]};
  assign qspi_dq_oe = r_oe;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block evaluation order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode, phase-length decode and request handshake.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_phase_last = 1'b0;
    req_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !reset;
        if (req_valid) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        w_phase_last = (r_cnt == 8'd7);
        if (w_end) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_phase_last = (r_cnt == 8'd23);
        if (w_end) w_state_nxt = (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin
        w_phase_last = (r_cnt == DUMMY_LAST);
        if (w_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_phase_last = (r_cnt == 8'd7);
        if (w_end) w_state_nxt = S_RESP;
      end
      S_RESP: begin
`ifdef QSPI_FLASH_BURST_EN
        if (resp_ready) w_state_nxt = S_HOLD;
`else
        if (resp_ready) w_state_nxt = S_DESEL;
`endif
      end
      S_DESEL: begin
`ifdef QSPI_FLASH_BURST_EN
        if (w_desel_done) w_state_nxt = r_pending ? S_CMD : S_IDLE;
`else
        if (w_desel_done) w_state_nxt = S_IDLE;
`endif
      end
`ifdef QSPI_FLASH_BURST_EN
      S_HOLD: begin
        req_ready = !reset;
        if (req_valid) w_state_nxt = w_seq ? S_DATA : S_DESEL;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SCK generation, shifting, nibble capture and registered pad controls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div        <= '0;
      r_sck        <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_resp_valid <= 1'b0;
      r_cs         <= 1'b1;
      r_oe         <= 4'b0000;
`ifdef QSPI_FLASH_BURST_EN
      r_addr       <= '0;
      r_pending    <= 1'b0;
`endif
    end else begin
      r_cs <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DESEL);
      r_oe <= ((w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR)) ? 4'b0001 : 4'b0000;
      if (w_active) begin
        if (w_tick) begin
          r_div <= '0;
          r_sck <= !r_sck;
        end else begin
          r_div <= r_div + 4'd1;
        end
        // Nibble j of the word: byte j/2, high nibble first.
        if (w_rise && (r_state == S_DATA))
          r_data[{r_cnt[2:1], !r_cnt[0], 2'b00} +: 4] <= qspi_dq_i;
        // A falling SCK edge ends one SCK cycle; the next bit goes out now.
        if (w_fall) begin
          r_cnt   <= w_phase_last ? 8'd0 : r_cnt + 8'd1;
          r_shift <= {r_shift[30:0], 1'b0};
        end
        if (w_end && (r_state == S_DATA)) r_resp_valid <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_shift <= {CMD_QOFR, w_addr_aligned};
          r_div   <= '0;
          r_sck   <= 1'b0;
          r_cnt   <= '0;
`ifdef QSPI_FLASH_BURST_EN
          r_addr  <= w_addr_aligned;
`endif
        end
        S_RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_cnt        <= '0;
        end
        S_DESEL: begin
          r_cnt <= r_cnt + 8'd1;
`ifdef QSPI_FLASH_BURST_EN
          if (w_desel_done && r_pending) begin
            r_shift   <= {CMD_QOFR, r_addr};
            r_div     <= '0;
            r_sck     <= 1'b0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
          end
`endif
        end
`ifdef QSPI_FLASH_BURST_EN
        S_HOLD: if (req_valid) begin
          r_addr <= w_addr_aligned;
          r_div  <= '0;
          r_sck  <= 1'b0;
          r_cnt  <= '0;
          if (!w_seq) r_pending <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
